// File: rtl/cube_scan_ctrl_pkg.sv
// rtl/cube_scan_ctrl_pkg.sv - shared states, geometry constants and helpers for the cube scanner
package cube_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ADDR,
        ST_CAP,
        ST_STROBE,
        ST_HOLD,
        ST_SHOW
    } scan_state_t;

    localparam int NUM_LAYERS  = 8;
    localparam int NUM_ROWS    = 8;
    localparam int ROW_W       = 3;
    localparam int LAYER_W     = 3;
    localparam int MEM_ADDR_W  = 6;
    localparam int LATCH_SEL_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cube_scan_ctrl_scan_timer.sv
// rtl/cube_scan_ctrl_scan_timer.sv - loadable down-counter with terminal-count flag
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/cube_scan_ctrl.sv
// rtl/cube_scan_ctrl.sv - layer-multiplexed 8x8x8 cube scan controller; optional BRIGHTNESS_EN dwell gating
module cube_scan_ctrl
    import cube_scan_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LATCH_PULSE  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [7:0]             mem_data,
    output logic [LATCH_SEL_W-1:0] latch_sel,
    output logic                   latch_en,
    output logic [7:0]             col_data,
    output logic [7:0]             layer_oe,
    output logic                   frame_done
`ifdef BRIGHTNESS_EN
    ,
    input  logic [3:0]             brightness
`endif
);

    localparam int CW = $clog2(max3(DWELL_CYCLES, BLANK_CYCLES, LATCH_PULSE)) + 1;
    localparam logic [CW-1:0] BLANK_LD   = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LD  = CW'(LATCH_PULSE - 1);
    localparam logic [CW-1:0] DWELL_LD   = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_FULL = CW'(DWELL_CYCLES);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    scan_state_t        state, next_state;
    logic [LAYER_W-1:0] layer;
    logic [ROW_W-1:0]   row, row_nx;
    logic               tmr_load, tmr_tc;
    logic [CW-1:0]      tmr_val, tmr_cnt;
    logic [CW-1:0]      next_elapsed, show_thr;
    logic               show_on;

    scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    next_state = ST_BLANK;
                    tmr_load   = 1'b1;
                    tmr_val    = BLANK_LD;
                end
            end
            ST_BLANK:  if (tmr_tc) next_state = ST_ADDR;
            ST_ADDR:   next_state = ST_CAP;
            ST_CAP: begin
                next_state = ST_STROBE;
                tmr_load   = 1'b1;
                tmr_val    = STROBE_LD;
            end
            ST_STROBE: if (tmr_tc) next_state = ST_HOLD;
            ST_HOLD: begin
                if (row == LAST_ROW) begin
                    next_state = ST_SHOW;
                    tmr_load   = 1'b1;
                    tmr_val    = DWELL_LD;
                end else begin
                    next_state = ST_ADDR;
                end
            end
            ST_SHOW: begin
                if (tmr_tc) begin
                    next_state = ST_BLANK;
                    tmr_load   = 1'b1;
                    tmr_val    = BLANK_LD;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
        if (!en) begin
            next_state = ST_IDLE;
            tmr_load   = 1'b0;
        end
    end

    // Outputs are registered, so layer_oe is decided one cycle ahead from the dwell position it will occupy.
    always_comb begin
        row_nx       = (state == ST_HOLD) ? row + 1'b1 : row;
        next_elapsed = (state == ST_SHOW) ? DWELL_FULL - tmr_cnt : '0;
        show_on      = (next_elapsed < show_thr);
    end

`ifdef BRIGHTNESS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            show_thr <= '0;
        end else if (state == ST_BLANK && next_state == ST_ADDR) begin
            show_thr <= CW'((DWELL_CYCLES * int'(brightness)) >> 4);
        end
    end
`else
    assign show_thr = DWELL_FULL;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            layer      <= '0;
            row        <= '0;
            mem_addr   <= '0;
            latch_sel  <= '0;
            latch_en   <= 1'b0;
            col_data   <= '0;
            layer_oe   <= '0;
            frame_done <= 1'b0;
        end else begin
            latch_en   <= (next_state == ST_STROBE);
            layer_oe   <= (next_state == ST_SHOW && show_on) ? (8'b1 << layer) : 8'b0;
            frame_done <= en && state == ST_SHOW && tmr_tc && layer == LAYER_W'(NUM_LAYERS - 1);
            if (!en) begin
                layer <= '0;
                row   <= '0;
            end else begin
                row <= row_nx;
                if (state == ST_SHOW && tmr_tc) begin
                    layer <= layer + 1'b1;
                end
            end
            if (next_state == ST_ADDR) begin
                mem_addr <= {layer, row_nx};
            end
            if (state == ST_CAP) begin
                col_data  <= mem_data;
                latch_sel <= {1'b0, row};
            end
        end
    end

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// tb/tb_cube_scan_ctrl.sv - scoreboard bench for cube_scan_ctrl (BRIGHTNESS_EN aware)
module tb_cube_scan_ctrl;

    localparam int DW   = 20;
    localparam int BL   = 2;
    localparam int LP   = 2;
    localparam int ROWC = LP + 3;
    localparam int PER  = BL + 8 * ROWC + DW;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [5:0] mem_addr;
    logic [7:0] mem_data;
    logic [3:0] latch_sel;
    logic       latch_en;
    logic [7:0] col_data, layer_oe;
    logic       frame_done;
`ifdef BRIGHTNESS_EN
    logic [3:0] brightness;
`endif

    cube_scan_ctrl #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .LATCH_PULSE  (LP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .latch_sel  (latch_sel),
        .latch_en   (latch_en),
        .col_data   (col_data),
        .layer_oe   (layer_oe),
        .frame_done (frame_done)
`ifdef BRIGHTNESS_EN
        ,
        .brightness (brightness)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] ram [64];
    always @(posedge clk) mem_data <= ram[mem_addr];

    typedef struct { int cyc; int sel; int data; } strobe_t;
    typedef struct { int cyc; int oe; } show_t;
    strobe_t sq[$];
    show_t   shq[$];
    int      fdq[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc;
    logic en_last;
    logic sb_on = 1'b0;
    int   bright = 16;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
        en_last <= en;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int show_len();
`ifdef BRIGHTNESS_EN
        return (DW * bright) >> 4;
`else
        return DW;
`endif
    endfunction

    // Expected events from the timing rules: each layer costs PER, each row ROWC, scan starts one cycle after enable.
    task automatic push_run(input int t0, input int nstrobe);
        strobe_t s;
        show_t   h;
        int      nfull;
        for (int k = 0; k < nstrobe; k++) begin
            s.cyc  = t0 + 1 + (k / 8) * PER + BL + 2 + (k % 8) * ROWC;
            s.sel  = k % 8;
            s.data = int'(ram[((k / 8) % 8) * 8 + (k % 8)]);
            sq.push_back(s);
        end
        nfull = nstrobe / 8;
        for (int l = 0; l < nfull; l++) begin
            if (show_len() > 0) begin
                h.cyc = t0 + 1 + l * PER + BL + 8 * ROWC;
                h.oe  = 1 << (l % 8);
                shq.push_back(h);
            end
        end
        for (int f = 1; f <= nfull / 8; f++) fdq.push_back(t0 + 1 + f * 8 * PER);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sq.size() == 0 && shq.size() == 0 && fdq.size() == 0) break;
            tick();
        end
        chk("drain_pending", sq.size() + shq.size() + fdq.size(), 0);
    endtask

    task automatic fill_ram(input bit pattern0);
        for (int a = 0; a < 64; a++) ram[a] = 8'($urandom);
        if (pattern0) for (int r = 0; r < 8; r++) ram[r] = 8'hA0 + 8'(r);
    endtask

    // Monitor: pops expectations when the DUT shows an event; checks invariants every cycle.
    initial begin
        logic    prev_le, prev_fd;
        logic [7:0] prev_oe;
        int      le_len, oe_len;
        strobe_t s;
        show_t   h;
        int      fc;
        prev_le = 0; prev_fd = 0; prev_oe = 0; le_len = 0; oe_len = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_le = 0; prev_fd = 0; prev_oe = 0; le_len = 0; oe_len = 0;
                continue;
            end
            chk("invariant", int'({latch_en & (|layer_oe), latch_sel[3], !$onehot0(layer_oe)}), 0);
            if (!en_last) chk("en_low_dark", int'({latch_en, |layer_oe, frame_done}), 0);
            if (latch_en && !prev_le) begin
                le_len = 1;
                if (sb_on) begin
                    chk("strobe_expected", int'(sq.size() > 0), 1);
                    if (sq.size() > 0) begin
                        s = sq.pop_front();
                        chk("strobe_cycle", cyc, s.cyc);
                        chk("latch_sel", int'(latch_sel), s.sel);
                        chk("col_data", int'(col_data), s.data);
                    end
                end
            end else if (latch_en) begin
                le_len++;
            end else if (prev_le && sb_on && en_last) begin
                chk("strobe_len", le_len, LP);
            end
            if (layer_oe != 0 && prev_oe == 0) begin
                oe_len = 1;
                if (sb_on) begin
                    chk("show_expected", int'(shq.size() > 0), 1);
                    if (shq.size() > 0) begin
                        h = shq.pop_front();
                        chk("show_cycle", cyc, h.cyc);
                        chk("layer_oe", int'(layer_oe), h.oe);
                    end
                end
            end else if (layer_oe != 0) begin
                oe_len++;
            end else if (prev_oe != 0 && sb_on && en_last) begin
                chk("show_len", oe_len, show_len());
            end
            if (frame_done) begin
                chk("frame_done_width", int'(prev_fd), 0);
                if (sb_on) begin
                    chk("frame_done_expected", int'(fdq.size() > 0), 1);
                    if (fdq.size() > 0) begin
                        fc = fdq.pop_front();
                        chk("frame_done_cycle", cyc, fc);
                    end
                end
            end
            prev_le = latch_en;
            prev_oe = layer_oe;
            prev_fd = frame_done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        en    = 1'b1;
        bright = 8;
`ifdef BRIGHTNESS_EN
        brightness = 4'(bright);
`endif
        fill_ram(1'b1);
        repeat (3) begin
            tick();
            chk("reset_outputs", int'({mem_addr, latch_sel, latch_en, col_data, layer_oe, frame_done}), 0);
        end

        // Full frame, then abort during the row-5 strobe of layer 3 of the next frame.
        sb_on = 1'b1;
        push_run(0, 8 * 11 + 6);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (sq.size() == 0) break;
        end
        chk("abort_reached", sq.size(), 0);
        en = 1'b0;
        tick();
        chk("abort_latch_en", int'(latch_en), 0);
        chk("abort_layer_oe", int'(layer_oe), 0);
        repeat (3) tick();
        chk("hold_latch_sel", int'(latch_sel), 5);
        chk("hold_col_data", int'(col_data), int'(ram[29]));
        chk("abort_queues", shq.size() + fdq.size(), 0);

        fill_ram(1'b0);
        t0 = cyc;
        push_run(t0, 64);
        en = 1'b1;
        repeat (3) tick();
        chk("restart_mem_addr", int'(mem_addr), 0);
        wait_drain(1000);

        // Random enable toggling; invariants only.
        sb_on = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            tick();
        end
        en = 1'b1;
        repeat ($urandom_range(20, 300)) tick();
        rst_n = 1'b0;
        tick();
        chk("midop_reset_outputs", int'({mem_addr, latch_sel, latch_en, col_data, layer_oe, frame_done}), 0);
        rst_n = 1'b1;
        en    = 1'b0;
        repeat (5) tick();

        sb_on = 1'b1;
`ifdef BRIGHTNESS_EN
        bright = 0;
        brightness = 4'(bright);
`endif
        fill_ram(1'b0);
        t0 = cyc;
        push_run(t0, 64);
        en = 1'b1;
        wait_drain(1000);
        en = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
